// File: rtl/mdu_div.sv
// Multi-cycle 32-bit divider for the EX stage: restoring shift-subtract, one quotient bit per cycle.
// Result is {remainder, quotient}, held in END until EX drops start_i.
module mdu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_BY_ZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        signed_q, signed_d;
    logic        neg1_q, neg1_d;
    logic        neg2_q, neg2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operands are reduced to magnitudes up front so the loop is purely unsigned.
    assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Partial remainder stays below the divisor, so the shifted value fits in 33 bits
    // and bit 32 of the difference is the borrow.
    assign trial   = {rem_q, quo_q[31]} - {1'b0, dvsr_q};

    assign quo_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = (signed_q && neg1_q) ? (~rem_q + 32'd1) : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        signed_d = signed_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    signed_d = signed_div_i;
                    neg1_d   = opdata1_i[31];
                    neg2_d   = opdata2_i[31];
                    quo_d    = op1_mag;
                    rem_d    = 32'd0;
                    dvsr_d   = op2_mag;
                    cnt_d    = 6'd0;
                    state_d  = (opdata2_i == 32'd0) ? S_BY_ZERO : S_ON;
                end
            end
            S_BY_ZERO: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = 64'd0;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end else if (cnt_q != 6'd32) begin
                    if (trial[32]) begin
                        rem_d = {rem_q[30:0], quo_q[31]};
                        quo_d = {quo_q[30:0], 1'b0};
                    end else begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    cnt_d    = 6'd0;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: begin
                state_d  = S_FREE;
                cnt_d    = 6'd0;
                ready_d  = 1'b0;
                result_d = 64'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            signed_q <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            signed_q <= signed_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    // Stall must be visible in the very cycle EX first raises start_i.
    assign stallreq_o = ~rst & start_i & ~annul_i & (state_q != S_END);

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed corner cases plus randomized divides
// compared against an arithmetic reference model.
module tb_mdu_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res;

    mdu_div dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: language-level division; longint avoids the -2^31 / -1 overflow.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Starts a divide and waits for ready_o; leaves start_i held so the block sits in END.
    task automatic start_and_wait(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  input string tag, output logic [63:0] res);
        logic [63:0] exp;
        int explat;
        int n;
        exp    = ref_div(sgn, a, b);
        explat = (b == 32'd0) ? 2 : 34;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        #1;
        chk({tag, "_stall_first"}, 64'(stallreq_o), 64'd1);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom);
            end
            if (ready_o === 1'b1) break;
        end
        chk({tag, "_latency"}, 64'(n), 64'(explat));
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_stall_end"}, 64'(stallreq_o), 64'd0);
        res = result_o;
        $display("div sgn=%0d a=%h b=%h -> hi=%h lo=%h edges=%0d", sgn, a, b,
                 result_o[63:32], result_o[31:0], n);
    endtask

    // One more END cycle with annul_i raised (must be ignored), then release start_i.
    task automatic hold_and_drop(input string tag, input logic [63:0] exp);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_hold_result"}, result_o, exp);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input string tag, output logic [63:0] res);
        start_and_wait(sgn, a, b, tag, res);
        hold_and_drop(tag, ref_div(sgn, a, b));
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;

        rst          = 1'b1;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 64'(stallreq_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7, "u100_7", last_res);
        chk("u100_7_const", last_res, {32'd2, 32'd14});
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "s-7_2", last_res);
        chk("s-7_2_const", last_res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_-2", last_res);
        chk("s7_-2_const", last_res, {32'h0000_0001, 32'hFFFF_FFFD});
        run_div(1'b0, 32'd5, 32'd0, "u5_0", last_res);
        chk("u5_0_const", last_res, 64'd0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "s_ovf", last_res);
        chk("s_ovf_const", last_res, {32'h0, 32'h8000_0000});
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "u_max_1", last_res);

        // Annul during ON, then restart right away.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, "after_annul", last_res);
        chk("after_annul_const", last_res, {32'd0, 32'd3});

        // Reset in the middle of ON.
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i    = 32'd12345;
        opdata2_i    = 32'd17;
        start_i      = 1'b1;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_on_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_on_ready", 64'(ready_o), 64'd0);
        chk("rst_on_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, "after_rst", last_res);

        // Reset while holding a result in END.
        start_and_wait(1'b0, 32'd1000, 32'd9, "rst_end", last_res);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_end_ready", 64'(ready_o), 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 15));
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            run_div(rs, ra, rb, $sformatf("rand%0d", i), last_res);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
